// File: rtl/conv_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_sched_pkg : shared types and defaults for the ping-pong conv sched  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
package conv_sched_pkg;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2
   } lane_state_e;

   localparam int C_DATA_N   = 128;
   localparam int C_FILTER_N = 32;
   localparam int C_OUT_W    = 21;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_lane_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_lane_tracker : per-lane load/drain state and x/f/y beat counters    |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module conv_lane_tracker
   import conv_sched_pkg::*;
#(
   parameter int DATA_N   = C_DATA_N,
   parameter int FILTER_N = C_FILTER_N,
   parameter int CONV_N   = C_DATA_N - C_FILTER_N + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_x_acc,
   input  logic        i_f_acc,
   input  logic        i_y_acc,
   output lane_state_e o_state,
   output logic        o_x_room,
   output logic        o_f_room,
   output logic        o_load_done,
   output logic        o_drain_done
);

   localparam int XW = cnt_width(DATA_N);
   localparam int FW = cnt_width(FILTER_N);
   localparam int YW = cnt_width(CONV_N - 1);
   localparam logic [XW-1:0] C_X_LAST = XW'(DATA_N);
   localparam logic [FW-1:0] C_F_LAST = FW'(FILTER_N);
   localparam logic [YW-1:0] C_Y_LAST = YW'(CONV_N - 1);

   lane_state_e   r_state;
   lane_state_e   w_state_nxt;
   logic [XW-1:0] r_x_cnt;
   logic [XW-1:0] w_x_nxt;
   logic [FW-1:0] r_f_cnt;
   logic [FW-1:0] w_f_nxt;
   logic [YW-1:0] r_y_cnt;

   // Completion is judged on the post-update counts so the last beat can be x, f or both.
   assign w_x_nxt      = r_x_cnt + XW'(i_x_acc);
   assign w_f_nxt      = r_f_cnt + FW'(i_f_acc);
   assign o_load_done  = (i_x_acc | i_f_acc) && (w_x_nxt == C_X_LAST) && (w_f_nxt == C_F_LAST);
   assign o_drain_done = i_y_acc && (r_y_cnt == C_Y_LAST);
   assign o_x_room     = (r_x_cnt < C_X_LAST);
   assign o_f_room     = (r_f_cnt < C_F_LAST);
   assign o_state      = r_state;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FREE: begin
            if (o_load_done)
               w_state_nxt = PEND;
            else if (i_x_acc | i_f_acc)
               w_state_nxt = LOAD;
         end
         LOAD: begin
            if (o_load_done)
               w_state_nxt = PEND;
         end
         PEND: begin
            if (o_drain_done)
               w_state_nxt = FREE;
         end
         default: w_state_nxt = FREE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= FREE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x_cnt <= '0;
         r_f_cnt <= '0;
         r_y_cnt <= '0;
      end else begin
         if (o_load_done) begin
            r_x_cnt <= '0;
            r_f_cnt <= '0;
         end else begin
            r_x_cnt <= w_x_nxt;
            r_f_cnt <= w_f_nxt;
         end
         if (o_drain_done)
            r_y_cnt <= '0;
         else if (i_y_acc)
            r_y_cnt <= r_y_cnt + YW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_pingpong_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pingpong_sched : shares one load stream and one result stream      |
// |                       between two conv lanes, results in job order      |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module conv_pingpong_sched
   import conv_sched_pkg::*;
#(
   parameter int DATA_N   = C_DATA_N,
   parameter int FILTER_N = C_FILTER_N,
   parameter int OUT_W    = C_OUT_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_valid_x,
   output logic                    s_ready_x,
   input  logic                    s_valid_f,
   output logic                    s_ready_f,
   output logic [1:0]              lane_s_valid_x,
   output logic [1:0]              lane_s_valid_f,
   input  logic [1:0]              lane_s_ready_x,
   input  logic [1:0]              lane_s_ready_f,
   input  logic [1:0]              lane_m_valid_y,
   output logic [1:0]              lane_m_ready_y,
   input  logic signed [OUT_W-1:0] lane_m_data_y0,
   input  logic signed [OUT_W-1:0] lane_m_data_y1,
   output logic                    m_valid_y,
   input  logic                    m_ready_y,
   output logic signed [OUT_W-1:0] m_data_out_y
);

   localparam int CONV_N = DATA_N - FILTER_N + 1;

   logic        r_ld_sel;
   logic        r_out_sel;
   lane_state_e w_state [2];
   logic [1:0]  w_x_room;
   logic [1:0]  w_f_room;
   logic [1:0]  w_load_done;
   logic [1:0]  w_drain_done;
   logic [1:0]  w_x_acc;
   logic [1:0]  w_f_acc;
   logic [1:0]  w_y_acc;
   logic        w_loadable;
   logic        w_out_pend;
   logic        w_x_fire;
   logic        w_f_fire;
   logic        w_y_fire;

   assign w_loadable = (w_state[r_ld_sel] != PEND);
   assign w_out_pend = (w_state[r_out_sel] == PEND);

   assign s_ready_x = lane_s_ready_x[r_ld_sel] & w_loadable & w_x_room[r_ld_sel];
   assign s_ready_f = lane_s_ready_f[r_ld_sel] & w_loadable & w_f_room[r_ld_sel];

   // Only the out_sel lane is ever forwarded, even if the other lane finishes first.
   assign m_valid_y    = lane_m_valid_y[r_out_sel] & w_out_pend;
   assign m_data_out_y = r_out_sel ? lane_m_data_y1 : lane_m_data_y0;

   always_comb begin
      lane_s_valid_x = 2'b00;
      lane_s_valid_f = 2'b00;
      lane_m_ready_y = 2'b00;
      lane_s_valid_x[r_ld_sel]  = s_valid_x & w_loadable & w_x_room[r_ld_sel];
      lane_s_valid_f[r_ld_sel]  = s_valid_f & w_loadable & w_f_room[r_ld_sel];
      lane_m_ready_y[r_out_sel] = m_ready_y & w_out_pend;
   end

   assign w_x_fire = s_valid_x & s_ready_x;
   assign w_f_fire = s_valid_f & s_ready_f;
   assign w_y_fire = m_valid_y & m_ready_y;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign w_x_acc[gi] = w_x_fire & (r_ld_sel == 1'(gi));
         assign w_f_acc[gi] = w_f_fire & (r_ld_sel == 1'(gi));
         assign w_y_acc[gi] = w_y_fire & (r_out_sel == 1'(gi));

         conv_lane_tracker #(
            .DATA_N   (DATA_N),
            .FILTER_N (FILTER_N),
            .CONV_N   (CONV_N)
         ) u_tracker (
            .clk          (clk),
            .reset        (reset),
            .i_x_acc      (w_x_acc[gi]),
            .i_f_acc      (w_f_acc[gi]),
            .i_y_acc      (w_y_acc[gi]),
            .o_state      (w_state[gi]),
            .o_x_room     (w_x_room[gi]),
            .o_f_room     (w_f_room[gi]),
            .o_load_done  (w_load_done[gi]),
            .o_drain_done (w_drain_done[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ld_sel  <= 1'b0;
         r_out_sel <= 1'b0;
      end else begin
         if (|w_load_done)
            r_ld_sel <= ~r_ld_sel;
         if (|w_drain_done)
            r_out_sel <= ~r_out_sel;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_pingpong_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_pingpong_sched : randomized job-queue model of conv_pingpong_sched |
// | Revision               : 1.0                                             |
// +--------------------------------------------------------------------------+
module tb_conv_pingpong_sched;

   localparam int DN = 128;
   localparam int FN = 32;
   localparam int CN = DN - FN + 1;
   localparam int OW = 21;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 s_valid_x = 1'b0;
   logic                 s_ready_x;
   logic                 s_valid_f = 1'b0;
   logic                 s_ready_f;
   logic [1:0]           lane_s_valid_x;
   logic [1:0]           lane_s_valid_f;
   logic [1:0]           lane_s_ready_x = 2'b00;
   logic [1:0]           lane_s_ready_f = 2'b00;
   logic [1:0]           lane_m_valid_y = 2'b00;
   logic [1:0]           lane_m_ready_y;
   logic signed [OW-1:0] lane_m_data_y0 = '0;
   logic signed [OW-1:0] lane_m_data_y1 = '0;
   logic                 m_valid_y;
   logic                 m_ready_y = 1'b0;
   logic signed [OW-1:0] m_data_out_y;

   always #5 clk = ~clk;

   conv_pingpong_sched #(
      .DATA_N   (DN),
      .FILTER_N (FN),
      .OUT_W    (OW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .s_valid_x      (s_valid_x),
      .s_ready_x      (s_ready_x),
      .s_valid_f      (s_valid_f),
      .s_ready_f      (s_ready_f),
      .lane_s_valid_x (lane_s_valid_x),
      .lane_s_valid_f (lane_s_valid_f),
      .lane_s_ready_x (lane_s_ready_x),
      .lane_s_ready_f (lane_s_ready_f),
      .lane_m_valid_y (lane_m_valid_y),
      .lane_m_ready_y (lane_m_ready_y),
      .lane_m_data_y0 (lane_m_data_y0),
      .lane_m_data_y1 (lane_m_data_y1),
      .m_valid_y      (m_valid_y),
      .m_ready_y      (m_ready_y),
      .m_data_out_y   (m_data_out_y)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Job-queue model: jobs are loaded in order (job k into lane k%2) and drained in order.
   int jobs_loaded  = 0;
   int jobs_drained = 0;
   int xb = 0;
   int fb = 0;
   int yb = 0;
   int target = 0;
   logic [1:0] lv_hold = 2'b00;

   int obs_x = 0;
   int obs_f = 0;
   int obs_y = 0;

   int pv_x, pv_f, p_lr, p_lv, p_mr;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [OW-1:0] yval(input int job, input int idx);
      return OW'((job * 4099 + idx * 517 + 12345) ^ 'h155555);
   endfunction

   // Job currently held by lane ln, or -1 when that lane has nothing pending.
   function automatic int lane_job(input int ln);
      if (jobs_drained < jobs_loaded && (jobs_drained % 2) == ln)
         return jobs_drained;
      if (jobs_drained + 1 < jobs_loaded && ((jobs_drained + 1) % 2) == ln)
         return jobs_drained + 1;
      return -1;
   endfunction

   function automatic logic rnd(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   task automatic run_cycle(input logic rst_in);
      int          lx, ly, k, idx;
      logic        loadable, exp_srx, exp_srf, exp_mv, x_fire, f_fire, y_fire;
      logic [1:0]  exp_lvx, exp_lvf, exp_lmr;
      logic [OW-1:0] d;
      @(negedge clk);
      reset = rst_in;
      if (rst_in) begin
         jobs_loaded = 0; jobs_drained = 0; xb = 0; fb = 0; yb = 0; lv_hold = 2'b00;
      end
      s_valid_x = (jobs_loaded < target) && rnd(pv_x);
      s_valid_f = (jobs_loaded < target) && rnd(pv_f);
      for (int ln = 0; ln < 2; ln++) begin
         lane_s_ready_x[ln] = rnd(p_lr);
         lane_s_ready_f[ln] = rnd(p_lr);
         k   = lane_job(ln);
         idx = (k == jobs_drained) ? yb : 0;
         lane_m_valid_y[ln] = (k >= 0) && (lv_hold[ln] || rnd(p_lv));
         d = (k >= 0) ? yval(k, idx) : OW'($urandom);
         if (ln == 0) lane_m_data_y0 = d;
         else         lane_m_data_y1 = d;
      end
      m_ready_y = rnd(p_mr);
      #1;
      lx       = jobs_loaded % 2;
      ly       = jobs_drained % 2;
      loadable = (jobs_loaded - jobs_drained) < 2;
      exp_srx  = lane_s_ready_x[lx] && loadable && (xb < DN);
      exp_srf  = lane_s_ready_f[lx] && loadable && (fb < FN);
      exp_lvx  = 2'b00;
      exp_lvf  = 2'b00;
      exp_lmr  = 2'b00;
      if (s_valid_x && loadable && xb < DN) exp_lvx[lx] = 1'b1;
      if (s_valid_f && loadable && fb < FN) exp_lvf[lx] = 1'b1;
      exp_mv = (jobs_drained < jobs_loaded) && lane_m_valid_y[ly];
      if (jobs_drained < jobs_loaded && m_ready_y) exp_lmr[ly] = 1'b1;

      chk_eq("s_ready_x", {31'd0, s_ready_x}, {31'd0, exp_srx});
      chk_eq("s_ready_f", {31'd0, s_ready_f}, {31'd0, exp_srf});
      chk_eq("lane_s_valid_x", {30'd0, lane_s_valid_x}, {30'd0, exp_lvx});
      chk_eq("lane_s_valid_f", {30'd0, lane_s_valid_f}, {30'd0, exp_lvf});
      chk_eq("m_valid_y", {31'd0, m_valid_y}, {31'd0, exp_mv});
      chk_eq("lane_m_ready_y", {30'd0, lane_m_ready_y}, {30'd0, exp_lmr});
      if (exp_mv)
         chk_eq("m_data_out_y", {11'd0, m_data_out_y}, {11'd0, yval(jobs_drained, yb)});

      x_fire = s_valid_x && exp_srx;
      f_fire = s_valid_f && exp_srf;
      y_fire = exp_mv && m_ready_y;
      if (!rst_in) begin
         if (s_valid_x && s_ready_x) obs_x++;
         if (s_valid_f && s_ready_f) obs_f++;
         if (m_valid_y && m_ready_y) obs_y++;
      end
      @(posedge clk);
      if (!rst_in) begin
         for (int ln = 0; ln < 2; ln++)
            lv_hold[ln] = lane_m_valid_y[ln] && !(y_fire && ly == ln);
         if (x_fire) xb++;
         if (f_fire) fb++;
         if (xb == DN && fb == FN) begin
            jobs_loaded++;
            xb = 0;
            fb = 0;
         end
         if (y_fire) begin
            yb++;
            if (yb == CN) begin
               yb = 0;
               jobs_drained++;
            end
         end
      end
   endtask

   task automatic run_jobs(input string tag, input int njobs, input int limit);
      int cyc = 0;
      int x0 = obs_x;
      int f0 = obs_f;
      int y0 = obs_y;
      target = target + njobs;
      while (jobs_drained < target && cyc < limit) begin
         run_cycle(1'b0);
         cyc++;
      end
      chk_eq({tag, "_x_beats"}, 32'(obs_x - x0), 32'(njobs * DN));
      chk_eq({tag, "_f_beats"}, 32'(obs_f - f0), 32'(njobs * FN));
      chk_eq({tag, "_results"}, 32'(obs_y - y0), 32'(njobs * CN));
   endtask

   task automatic set_knobs(input int vx, input int vf, input int lr, input int lv, input int mr);
      pv_x = vx; pv_f = vf; p_lr = lr; p_lv = lv; p_mr = mr;
   endtask

   initial begin
      int cyc;
      set_knobs(100, 100, 100, 100, 100);
      for (int i = 0; i < 3; i++) run_cycle(1'b1);

      // single job, everything always ready
      run_jobs("single", 1, 2000);

      // back-to-back: loads of the next job overlap the drain of the previous one
      run_jobs("b2b", 3, 4000);

      // slow drain so both lanes go PEND and later results wait behind earlier ones
      set_knobs(100, 100, 100, 100, 8);
      run_jobs("both_pend", 3, 12000);

      // random valids/readies everywhere, 50% downstream backpressure
      set_knobs(60, 60, 70, 70, 50);
      run_jobs("random", 3, 12000);

      // abort a job after 60 x beats, then a fresh job from lane 0
      set_knobs(100, 100, 100, 100, 100);
      target = target + 1;
      cyc = 0;
      while (xb < 60 && cyc < 1000) begin
         run_cycle(1'b0);
         cyc++;
      end
      chk_eq("pre_reset_x_beats", 32'(xb), 32'd60);
      run_cycle(1'b1);
      run_cycle(1'b1);
      target = 0;
      run_jobs("after_reset", 1, 2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
